// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int          INST_BYTES        = 4;
  localparam int          FETCH_XLEN        = 32;
  localparam logic [31:0] DEFAULT_IMEM_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           word;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO holding fetched {pc, word} pairs for decode.
// The head reads as all zeros while the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fq_entry_t                push_entry,
  input  logic                     pop,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fq_entry_t           storage [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      storage[wr_ptr] <= push_entry;
    end
  end

  // Present the oldest entry, or zeros when nothing is queued.
  always_comb begin
    head = '0;
    if (count != '0) begin
      head = storage[rd_ptr];
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, reads the combinational instruction
// memory, buffers words in a small queue and hands them to decode.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] IMEM_BASE  = DEFAULT_IMEM_BASE,
  parameter int              IMEM_DEPTH = 3000,
  parameter int              FQ_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_word,
  output logic [XLEN-1:0] inst_pc,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  fetch_state_e     state;
  fetch_state_e     state_n;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  fetch_pc_n;
  logic [XLEN-1:0]  fault_pc_n;

  logic [XLEN:0]    pc_ext;
  logic [XLEN:0]    base_ext;
  logic [XLEN:0]    limit_ext;
  logic             pc_ok;
  logic             enq;
  logic             deq;

  fq_entry_t        push_entry;
  fq_entry_t        head;
  logic [CNT_W-1:0] count;

  // Range and alignment check done one bit wider so the limit never wraps.
  always_comb begin
    pc_ext    = {1'b0, fetch_pc};
    base_ext  = {1'b0, IMEM_BASE};
    limit_ext = base_ext + (XLEN+1)'(INST_BYTES * IMEM_DEPTH);
    pc_ok     = (fetch_pc[1:0] == 2'b00) && (pc_ext >= base_ext) && (pc_ext < limit_ext);
  end

  assign imem_addr  = pc_ok ? fetch_pc : IMEM_BASE;
  assign inst_valid = (count != '0) && !redirect_valid;
  assign deq        = inst_valid && inst_ready;
  assign enq        = (state == RUN) && pc_ok && !halt && !redirect_valid &&
                      ((count < CNT_W'(FQ_DEPTH)) || deq);

  assign push_entry = '{pc: fetch_pc, word: imem_rdata};
  assign inst_word  = head.word;
  assign inst_pc    = head.pc;
  assign fault      = (state == FAULT);

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (enq),
    .push_entry (push_entry),
    .pop        (deq),
    .head       (head),
    .count      (count)
  );

  // Controller state, fetch PC and captured fault address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      fetch_pc <= IMEM_BASE;
      fault_pc <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      fault_pc <= fault_pc_n;
    end
  end

  // Next-state and PC update; a redirect overrides everything else.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    fault_pc_n = fault_pc;
    if (redirect_valid) begin
      state_n    = RUN;
      fetch_pc_n = redirect_pc;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state_n = HALT;
          end else if (!pc_ok) begin
            state_n    = FAULT;
            fault_pc_n = fetch_pc;
          end else if (enq) begin
            fetch_pc_n = fetch_pc + XLEN'(INST_BYTES);
          end
        end
        HALT: begin
          if (!halt) begin
            state_n = RUN;
          end
        end
        FAULT: begin
          state_n = FAULT;
        end
        default: begin
          state_n = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl with a PC scoreboard.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 3000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mon_pc;

  imem_fetch_ctrl #(
    .XLEN       (32),
    .IMEM_BASE  (BASE),
    .IMEM_DEPTH (DEPTH),
    .FQ_DEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_pc        (inst_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE) >> 2;
    case (idx)
      32'd0:   return 32'h0050_0093;
      32'd1:   return 32'h0010_0113;
      32'd2:   return 32'h0020_81B3;
      default: return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic h, input logic rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    inst_ready     = rdy;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(start + 32'(4 * i));
    end
  endtask

  task automatic do_reset(input logic rdy);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, rdy);
    sb_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_sb_empty(input int max_cycles);
    for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) begin
      at_neg();
    end
    checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every accepted instruction must match the next expected PC.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready && sb_q.size() > 0) begin
      mon_pc = sb_q.pop_front();
      checkOutput("sb_pc", inst_pc, mon_pc);
      checkOutput("sb_word", inst_word, mem_word(mon_pc));
    end
  end

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int found;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset values and streaming start-up
    do_reset(1'b1);
    push_seq(BASE, 3);
    at_neg();
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_fault_pc", fault_pc, 32'h0);
    checkOutput("rst_imem_addr", imem_addr, BASE);
    checkOutput("rst_inst_word", inst_word, 32'h0);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    at_neg();
    checkOutput("t1_valid", 32'(inst_valid), 32'd1);
    checkOutput("t1_pc0", inst_pc, 32'h8000_0000);
    checkOutput("t1_w0", inst_word, 32'h0050_0093);
    at_neg();
    checkOutput("t1_pc1", inst_pc, 32'h8000_0004);
    checkOutput("t1_w1", inst_word, 32'h0010_0113);
    at_neg();
    checkOutput("t1_pc2", inst_pc, 32'h8000_0008);
    checkOutput("t1_w2", inst_word, 32'h0020_81B3);
    wait_sb_empty(10);

    // Backpressure: queue fills at two entries and the fetch address holds
    do_reset(1'b0);
    push_seq(BASE, 8);
    repeat (5) at_neg();
    checkOutput("t2_imem_addr", imem_addr, 32'h8000_0008);
    checkOutput("t2_valid", 32'(inst_valid), 32'd1);
    checkOutput("t2_head", inst_pc, BASE);
    tick();
    inst_ready = 1'b1;
    wait_sb_empty(20);

    // Redirect with a full queue
    do_reset(1'b0);
    repeat (4) at_neg();
    tick();
    sb_q.delete();
    push_seq(32'h8000_0100, 4);
    applyStimulus(1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b1);
    at_neg();
    checkOutput("t3_redir_valid", 32'(inst_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    wait_sb_empty(20);

    // Misaligned redirect faults; a later redirect clears it
    tick();
    sb_q.delete();
    applyStimulus(1'b0, 1'b1, 32'h8000_0102, 1'b0, 1'b1);
    tick();
    redirect_valid = 1'b0;
    at_neg();
    checkOutput("t4_imem_addr", imem_addr, BASE);
    checkOutput("t4_no_enq", 32'(inst_valid), 32'd0);
    at_neg();
    checkOutput("t4_fault", 32'(fault), 32'd1);
    checkOutput("t4_fault_pc", fault_pc, 32'h8000_0102);
    checkOutput("t4_valid", 32'(inst_valid), 32'd0);
    tick();
    halt = 1'b1;
    repeat (2) at_neg();
    checkOutput("t4_fault_hold", 32'(fault), 32'd1);
    tick();
    halt = 1'b0;
    push_seq(BASE, 4);
    applyStimulus(1'b0, 1'b1, BASE, 1'b0, 1'b1);
    tick();
    redirect_valid = 1'b0;
    at_neg();
    checkOutput("t4_fault_clr", 32'(fault), 32'd0);
    checkOutput("t4_fault_pc_kept", fault_pc, 32'h8000_0102);
    wait_sb_empty(20);

    // Sequential run off the end of memory
    do_reset(1'b1);
    push_seq(BASE, DEPTH);
    found = 0;
    for (int i = 0; i < DEPTH + 100 && found == 0; i++) begin
      at_neg();
      if (inst_valid && inst_pc == BASE + 32'(4 * (DEPTH - 1))) found = 1;
    end
    checkOutput("t5_last_seen", 32'(found), 32'd1);
    if (found != 0) begin
      checkOutput("t5_fault_with_last", 32'(fault), 32'd0);
      at_neg();
      checkOutput("t5_fault", 32'(fault), 32'd1);
      checkOutput("t5_fault_pc", fault_pc, BASE + 32'(4 * DEPTH));
      checkOutput("t5_valid", 32'(inst_valid), 32'd0);
    end
    wait_sb_empty(2);

    // Halt drains the queue, then fetch resumes at the next PC
    do_reset(1'b0);
    push_seq(BASE, 6);
    repeat (3) at_neg();
    tick();
    halt       = 1'b1;
    inst_ready = 1'b1;
    repeat (3) at_neg();
    checkOutput("t6_halt_empty", 32'(inst_valid), 32'd0);
    at_neg();
    checkOutput("t6_halt_empty2", 32'(inst_valid), 32'd0);
    checkOutput("t6_halt_addr", imem_addr, 32'h8000_0008);
    tick();
    halt = 1'b0;
    wait_sb_empty(20);

    // Reset in the middle of a stream
    do_reset(1'b1);
    repeat (6) at_neg();
    tick();
    rst = 1'b1;
    sb_q.delete();
    push_seq(BASE, 4);
    tick();
    rst = 1'b0;
    at_neg();
    checkOutput("t6_rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("t6_rst_pc", inst_pc, 32'h0);
    wait_sb_empty(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
